// File: rtl/sram_arb_2p.sv
// Two-requester round-robin arbiter in front of a single-port SRAM macro.
// Commands are registered onto the macro pins; read data returns three cycles after accept.
module sram_arb_2p #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  // requester A
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [15:0]           a_count,
  // requester B
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [15:0]           b_count,
  // SRAM macro port
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Response tag travelling alongside each SRAM command.
  typedef struct packed {
    logic  read;
    port_e port;
  } tag_t;

  port_e                 last_grant;
  tag_t                  tag_cmd;
  tag_t                  tag_data;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  port_e                 sel_port;

  // Round-robin grant: on a tie, the port not granted last time wins.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst_n) begin
      if (a_valid && (!b_valid || last_grant == PORT_B)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  // Mux the winning requester's command onto the SRAM side.
  always_comb begin
    accept    = a_ready | b_ready;
    sel_port  = b_ready ? PORT_B : PORT_A;
    sel_we    = b_ready ? b_we    : a_we;
    sel_addr  = b_ready ? b_addr  : a_addr;
    sel_wdata = b_ready ? b_wdata : a_wdata;
  end

  // SRAM pin register and grant history.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      csb0       <= 1'b1;
      web0       <= 1'b1;
      addr0      <= '0;
      din0       <= '0;
      last_grant <= PORT_B;
    end else begin
      csb0 <= ~accept;
      web0 <= accept ? ~sel_we : 1'b1;
      if (accept) begin
        addr0      <= sel_addr;
        din0       <= sel_wdata;
        last_grant <= sel_port;
      end
    end
  end

  // Tag pipeline: tag_cmd aligns with the pin cycle, tag_data with dout0.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      tag_cmd  <= '{read: 1'b0, port: PORT_A};
      tag_data <= '{read: 1'b0, port: PORT_A};
    end else begin
      tag_cmd  <= '{read: accept && !sel_we, port: sel_port};
      tag_data <= tag_cmd;
    end
  end

  // Capture read data for the tagged port and pulse its rvalid.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= tag_data.read && (tag_data.port == PORT_A);
      b_rvalid <= tag_data.read && (tag_data.port == PORT_B);
      if (tag_data.read && tag_data.port == PORT_A) begin
        a_rdata <= dout0;
      end
      if (tag_data.read && tag_data.port == PORT_B) begin
        b_rdata <= dout0;
      end
    end
  end

  // Saturating accepted-command counters.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (a_ready && a_count != CNT_MAX) begin
        a_count <= a_count + CNT_WIDTH'(1);
      end
      if (b_ready && b_count != CNT_MAX) begin
        b_count <= b_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
